// File: rtl/fixq_pkg.sv
// Shared types and sizing for the fixed-point shift-add multiplier.
// FIXQ_MUL_RADIX4_EN selects two multiplier bits per step instead of one.
package fixq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int QW_DEF   = 40;
    localparam int DW_DEF   = 32;
    localparam int FRAC_DEF = 8;
    localparam int PW       = QW_DEF + DW_DEF;

`ifdef FIXQ_MUL_RADIX4_EN
    localparam int RADIX_BITS = 2;
`else
    localparam int RADIX_BITS = 1;
`endif

    // Number of RUN cycles needed to retire a qw-bit multiplier.
    function automatic int steps(input int qw);
        return qw / RADIX_BITS;
    endfunction

endpackage

// File: rtl/fixq_pp_sel.sv
// Partial-product select for one multiplier step (radix-2, or radix-4 when
// FIXQ_MUL_RADIX4_EN is defined).
module fixq_pp_sel
    import fixq_pkg::*;
#(
    parameter int W = PW
) (
`ifdef FIXQ_MUL_RADIX4_EN
    input  logic [1:0]   mult_bits,
    input  logic [W-1:0] ds_sh,
    input  logic [W-1:0] ds3_sh,
`else
    input  logic         mult_bit,
    input  logic [W-1:0] ds_sh,
`endif
    output logic [W-1:0] pp
);

`ifdef FIXQ_MUL_RADIX4_EN
    always_comb begin
        pp = '0;
        unique case (mult_bits)
            2'd0: pp = '0;
            2'd1: pp = ds_sh;
            2'd2: pp = ds_sh << 1;
            2'd3: pp = ds3_sh;
            default: pp = '0;
        endcase
    end
`else
    always_comb begin
        pp = mult_bit ? ds_sh : '0;
    end
`endif

endmodule

// File: rtl/fixq_multiplier.sv
// Sequential shift-add multiplier: unsigned 32.8 quotient x 32-bit divisor -> 64.8.
// Define FIXQ_MUL_RADIX4_EN for 2 bits/cycle (20-cycle latency instead of 40).
module fixq_multiplier
    import fixq_pkg::*;
#(
    parameter int QW   = QW_DEF,
    parameter int DW   = DW_DEF,
    parameter int FRAC = FRAC_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [QW-1:0]      q_in,
    input  logic [DW-1:0]      ds_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [QW+DW-1:0]   prod,
    output logic [DW-1:0]      prod_int,
    output logic               ovf
);

    localparam int PROD_W = QW + DW;
    localparam int NSTEPS = steps(QW);
    localparam int CW     = $clog2(NSTEPS);

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q;
    logic [QW-1:0]       mult_q;
    logic [PROD_W-1:0]   ds_sh_q;
    logic [PROD_W-1:0]   acc_q;
    logic [PROD_W-1:0]   prod_q;
    logic [PROD_W-1:0]   pp;
    logic [PROD_W-1:0]   acc_next;
    logic                accept;
`ifdef FIXQ_MUL_RADIX4_EN
    logic [PROD_W-1:0]   ds3_sh_q;
`endif

`ifdef FIXQ_MUL_RADIX4_EN
    fixq_pp_sel #(.W(PROD_W)) u_pp_sel (
        .mult_bits (mult_q[1:0]),
        .ds_sh     (ds_sh_q),
        .ds3_sh    (ds3_sh_q),
        .pp        (pp)
    );
`else
    fixq_pp_sel #(.W(PROD_W)) u_pp_sel (
        .mult_bit  (mult_q[0]),
        .ds_sh     (ds_sh_q),
        .pp        (pp)
    );
`endif

    assign accept   = in_valid && in_ready;
    assign acc_next = acc_q + pp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = RUN;
            end
            RUN: begin
                if (cnt_q == '0) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // The shifted divisor walks up one weight per step while the multiplier
    // walks down, so each step only needs an add, never a barrel shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            mult_q   <= '0;
            ds_sh_q  <= '0;
            acc_q    <= '0;
            prod_q   <= '0;
`ifdef FIXQ_MUL_RADIX4_EN
            ds3_sh_q <= '0;
`endif
        end else if (accept) begin
            cnt_q    <= CW'(NSTEPS - 1);
            mult_q   <= q_in;
            ds_sh_q  <= PROD_W'(ds_in);
            acc_q    <= '0;
`ifdef FIXQ_MUL_RADIX4_EN
            ds3_sh_q <= PROD_W'(ds_in) + (PROD_W'(ds_in) << 1);
`endif
        end else if (state_q == RUN) begin
            cnt_q    <= cnt_q - CW'(1);
            mult_q   <= mult_q >> RADIX_BITS;
            ds_sh_q  <= ds_sh_q << RADIX_BITS;
            acc_q    <= acc_next;
`ifdef FIXQ_MUL_RADIX4_EN
            ds3_sh_q <= ds3_sh_q << RADIX_BITS;
`endif
            if (cnt_q == '0) prod_q <= acc_next;
        end
    end

    assign prod     = prod_q;
    assign prod_int = prod_q[DW+FRAC-1:FRAC];
    assign ovf      = |prod_q[PROD_W-1:DW+FRAC];

endmodule

// File: tb/tb_fixq_multiplier.sv
// Self-checking bench for fixq_multiplier using a queue of expected products.
// Honours FIXQ_MUL_RADIX4_EN for the expected latency.
module tb_fixq_multiplier;

    localparam int QW = 40;
    localparam int DW = 32;
    localparam int PW = QW + DW;
`ifdef FIXQ_MUL_RADIX4_EN
    localparam int LAT = 20;
`else
    localparam int LAT = 40;
`endif
    localparam int NRAND = 1000;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [QW-1:0] q_in;
    logic [DW-1:0] ds_in;
    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] prod;
    logic [DW-1:0] prod_int;
    logic          ovf;

    int vectors     = 0;
    int miscompares = 0;
    logic [PW-1:0] exp_q[$];

    fixq_multiplier dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .q_in      (q_in),
        .ds_in     (ds_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .prod      (prod),
        .prod_int  (prod_int),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Drives one operand pair at a negedge and pushes the reference product.
    task automatic send(input logic [QW-1:0] q, input logic [DW-1:0] ds, output bit ok);
        int n = 0;
        ok = 1'b0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (in_ready) begin
            q_in     = q;
            ds_in    = ds;
            in_valid = 1'b1;
            exp_q.push_back(PW'(q) * PW'(ds));
            @(negedge clk);
            in_valid = 1'b0;
            q_in     = {8'($urandom), $urandom};
            ds_in    = $urandom;
            ok       = 1'b1;
        end
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        if (!out_valid) lat = -1;
    endtask

    task automatic test_reset;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        q_in      = '0;
        ds_in     = '0;
        repeat (2) @(negedge clk);
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
        vectors++; if (prod !== '0) begin miscompares++; $display("[TB] FAIL reset_prod: got %h expected 0", prod); end
        vectors++; if (prod_int !== '0) begin miscompares++; $display("[TB] FAIL reset_prod_int: got %h expected 0", prod_int); end
        vectors++; if (ovf !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_ovf: got %b expected 0", ovf); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        bit ok;
        int lat;
        logic [PW-1:0] e;
        out_ready = 1'b1;
        send(40'h0000000380, 32'd2, ok);
        vectors++; if (!ok) begin miscompares++; $display("[TB] FAIL basic_accept: got no accept expected accept"); end
        wait_valid(lat);
        vectors++; if (lat != LAT) begin miscompares++; $display("[TB] FAIL basic_latency: got %0d expected %0d", lat, LAT); end
        e = exp_q.pop_front();
        vectors++; if (prod !== e) begin miscompares++; $display("[TB] FAIL basic_prod: got %h expected %h", prod, e); end
        vectors++; if (prod !== 72'h700) begin miscompares++; $display("[TB] FAIL basic_prod_const: got %h expected 700", prod); end
        vectors++; if (prod_int !== 32'd7) begin miscompares++; $display("[TB] FAIL basic_prod_int: got %h expected 7", prod_int); end
        vectors++; if (ovf !== 1'b0) begin miscompares++; $display("[TB] FAIL basic_ovf: got %b expected 0", ovf); end
        @(negedge clk);
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL basic_pulse: got out_valid %b expected 0", out_valid); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL basic_ready_after: got %b expected 1", in_ready); end
        out_ready = 1'b0;
    endtask

    task automatic test_max;
        bit ok;
        int lat;
        logic [PW-1:0] e;
        logic [PW-1:0] c;
        c = 72'hFFFFFFFEFF00000001;
        send(40'hFFFFFFFFFF, 32'hFFFFFFFF, ok);
        vectors++; if (!ok) begin miscompares++; $display("[TB] FAIL max_accept: got no accept expected accept"); end
        wait_valid(lat);
        vectors++; if (lat != LAT) begin miscompares++; $display("[TB] FAIL max_latency: got %0d expected %0d", lat, LAT); end
        e = exp_q.pop_front();
        vectors++; if (prod !== e) begin miscompares++; $display("[TB] FAIL max_prod: got %h expected %h", prod, e); end
        vectors++; if (prod !== c) begin miscompares++; $display("[TB] FAIL max_prod_const: got %h expected %h", prod, c); end
        vectors++; if (prod_int !== c[39:8]) begin miscompares++; $display("[TB] FAIL max_prod_int: got %h expected %h", prod_int, c[39:8]); end
        vectors++; if (ovf !== 1'b1) begin miscompares++; $display("[TB] FAIL max_ovf: got %b expected 1", ovf); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_zero_busy;
        bit ok;
        bit busy_ok = 1'b1;
        bit extra   = 1'b0;
        int lat;
        logic [PW-1:0] e;
        send(40'h0, 32'h12345678, ok);
        vectors++; if (!ok) begin miscompares++; $display("[TB] FAIL zero_accept: got no accept expected accept"); end
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
            if (lat == 5 || lat == 12 || lat == 17) begin
                if (in_ready !== 1'b0) busy_ok = 1'b0;
                in_valid = 1'b1;
                q_in     = 40'h00000FF00;
                ds_in    = 32'h0000FFFF;
            end else begin
                in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        if (!out_valid) lat = -1;
        vectors++; if (!busy_ok) begin miscompares++; $display("[TB] FAIL zero_busy_ready: got in_ready 1 during RUN expected 0"); end
        vectors++; if (lat != LAT) begin miscompares++; $display("[TB] FAIL zero_latency: got %0d expected %0d", lat, LAT); end
        e = exp_q.pop_front();
        vectors++; if (prod !== e) begin miscompares++; $display("[TB] FAIL zero_prod: got %h expected %h", prod, e); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        repeat (LAT + 5) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || in_ready !== 1'b1) extra = 1'b1;
        end
        vectors++; if (extra) begin miscompares++; $display("[TB] FAIL zero_ignored: got queued operation expected none"); end
    endtask

    task automatic test_hold;
        bit ok;
        bit stable = 1'b1;
        int lat;
        logic [PW-1:0] e;
        send(40'h12_3456_7890, 32'hDEADBEEF, ok);
        vectors++; if (!ok) begin miscompares++; $display("[TB] FAIL hold_accept: got no accept expected accept"); end
        wait_valid(lat);
        vectors++; if (lat != LAT) begin miscompares++; $display("[TB] FAIL hold_latency: got %0d expected %0d", lat, LAT); end
        e = exp_q.pop_front();
        repeat (10) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || prod !== e || in_ready !== 1'b0) stable = 1'b0;
        end
        vectors++; if (!stable) begin miscompares++; $display("[TB] FAIL hold_stable: got changing output expected held %h", e); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL hold_ready_after: got %b expected 1", in_ready); end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL hold_valid_after: got %b expected 0", out_valid); end
        vectors++; if (prod !== e) begin miscompares++; $display("[TB] FAIL hold_prod_after: got %h expected %h", prod, e); end
    endtask

    task automatic test_reset_mid_run;
        bit ok;
        int lat;
        logic [PW-1:0] e;
        send(40'hAB_CDEF_0123, 32'h87654321, ok);
        vectors++; if (!ok) begin miscompares++; $display("[TB] FAIL midrst_accept: got no accept expected accept"); end
        repeat (17) @(negedge clk);
        rst_n = 1'b0;
        #1;
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL midrst_in_ready: got %b expected 1", in_ready); end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL midrst_out_valid: got %b expected 0", out_valid); end
        vectors++; if (prod !== '0) begin miscompares++; $display("[TB] FAIL midrst_prod: got %h expected 0", prod); end
        vectors++; if (ovf !== 1'b0) begin miscompares++; $display("[TB] FAIL midrst_ovf: got %b expected 0", ovf); end
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(40'h100, 32'd5, ok);
        vectors++; if (!ok) begin miscompares++; $display("[TB] FAIL midrst_fresh_accept: got no accept expected accept"); end
        wait_valid(lat);
        vectors++; if (lat != LAT) begin miscompares++; $display("[TB] FAIL midrst_latency: got %0d expected %0d", lat, LAT); end
        e = exp_q.pop_front();
        vectors++; if (prod !== e) begin miscompares++; $display("[TB] FAIL midrst_prod_model: got %h expected %h", prod, e); end
        vectors++; if (prod !== 72'h500) begin miscompares++; $display("[TB] FAIL midrst_prod_const: got %h expected 500", prod); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back;
        bit ok;
        int lat;
        int results = 0;
        logic [PW-1:0] e;
        logic [QW-1:0] q;
        logic [DW-1:0] ds;
        for (int i = 0; i < NRAND; i++) begin
            q  = {8'($urandom), $urandom};
            ds = $urandom;
            if (i % 97 == 3)  q  = '1;
            if (i % 89 == 5)  ds = '1;
            if (i % 83 == 7)  q  = '0;
            send(q, ds, ok);
            vectors++; if (!ok) begin miscompares++; $display("[TB] FAIL b2b_accept[%0d]: got no accept expected accept", i); end
            wait_valid(lat);
            vectors++; if (lat != LAT) begin miscompares++; $display("[TB] FAIL b2b_latency[%0d]: got %0d expected %0d", i, lat, LAT); end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            if (exp_q.size() == 0) begin
                vectors++; miscompares++;
                $display("[TB] FAIL b2b_extra[%0d]: got result %h expected none", i, prod);
            end else begin
                e = exp_q.pop_front();
                vectors++; if (prod !== e) begin miscompares++; $display("[TB] FAIL b2b_prod[%0d]: got %h expected %h", i, prod, e); end
                vectors++; if (prod_int !== e[39:8] || ovf !== (|e[71:40])) begin
                    miscompares++;
                    $display("[TB] FAIL b2b_int_ovf[%0d]: got %h/%b expected %h/%b", i, prod_int, ovf, e[39:8], |e[71:40]);
                end
            end
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            results++;
            vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_dup[%0d]: got out_valid %b expected 0", i, out_valid); end
        end
        vectors++; if (exp_q.size() != 0) begin miscompares++; $display("[TB] FAIL b2b_lost: got %0d pending expected 0", exp_q.size()); end
        vectors++; if (results != NRAND) begin miscompares++; $display("[TB] FAIL b2b_count: got %0d expected %0d", results, NRAND); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_max();
        test_zero_busy();
        test_hold();
        test_reset_mid_run();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
